mips_mc_ctrl: RTL and testbench



---
 rtl/mips_pkg.sv | 43 ++++
 rtl/mips_mc_ctrl_if.sv | 34 +++
 rtl/mips_opdec.sv | 22 ++
 rtl/mips_mc_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, ALU op encodings and controller state types
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_R,
    S_WB_I,
    S_WB_MEM,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_ILL
  } instr_cls_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// rtl/mips_mc_ctrl_if.sv - controller to datapath strobe bundle
interface mips_mc_ctrl_if;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        pc_we;
  logic        pcsel;
  logic        jmp;
  logic        ir_we;
  logic        mem_rd;
  logic        mem_wr;
  logic        reg_we;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        alu_src_b;
  logic [2:0]  alu_op;
  logic        illegal;
  logic [31:0] retired;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, pcsel, jmp, ir_we, mem_rd, mem_wr, reg_we, reg_dst,
           mem_to_reg, alu_src_b, alu_op, illegal, retired
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, pcsel, jmp, ir_we, mem_rd, mem_wr, reg_we, reg_dst,
           mem_to_reg, alu_src_b, alu_op, illegal, retired
  );

endinterface

// File: rtl/mips_opdec.sv
// rtl/mips_opdec.sv - combinational opcode to instruction-class decode
module mips_opdec
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output instr_cls_t cls
);

  always_comb begin
    cls = CLS_ILL;
    case (opcode)
      OP_RTYPE: cls = CLS_R;
      OP_ADDI:  cls = CLS_I;
      OP_LW:    cls = CLS_LW;
      OP_SW:    cls = CLS_SW;
      OP_BEQ:   cls = CLS_BEQ;
      OP_J:     cls = CLS_J;
      default:  cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle MIPS main controller (fetch/decode/exec/mem/wb)
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  mips_mc_ctrl_if.master bus
);

  state_t     state;
  state_t     next_state;
  instr_cls_t cls;
  logic [31:0] retired_cnt;

  logic    pc_we_i;
  logic    pcsel_i;
  logic    jmp_i;
  logic    ir_we_i;
  logic    mem_rd_i;
  logic    mem_wr_i;
  logic    reg_we_i;
  logic    reg_dst_i;
  logic    mem_to_reg_i;
  logic    alu_src_b_i;
  alu_op_t alu_op_i;

  // funct is consumed by the ALU control in the datapath, not here
  logic unused_funct;
  assign unused_funct = ^bus.funct;

  mips_opdec u_opdec (
    .opcode (bus.opcode),
    .cls    (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= 32'd0;
    end else if (pc_we_i) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end

  always_comb begin
    next_state   = state;
    pc_we_i      = 1'b0;
    pcsel_i      = 1'b0;
    jmp_i        = 1'b0;
    ir_we_i      = 1'b0;
    mem_rd_i     = 1'b0;
    mem_wr_i     = 1'b0;
    reg_we_i     = 1'b0;
    reg_dst_i    = 1'b0;
    mem_to_reg_i = 1'b0;
    alu_src_b_i  = 1'b0;
    alu_op_i     = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_rd_i = 1'b1;
        if (bus.mem_ready) begin
          ir_we_i    = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cls)
          CLS_R:   next_state = S_EXEC_R;
          CLS_I:   next_state = S_EXEC_I;
          CLS_LW:  next_state = S_ADDR;
          CLS_SW:  next_state = S_ADDR;
          CLS_BEQ: next_state = S_BRANCH;
          CLS_J:   next_state = S_JUMP;
          default: next_state = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_op_i   = ALU_FUNCT;
        next_state = S_WB_R;
      end
      S_WB_R: begin
        reg_we_i   = 1'b1;
        reg_dst_i  = 1'b1;
        pc_we_i    = 1'b1;
        next_state = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_b_i = 1'b1;
        next_state  = S_WB_I;
      end
      S_WB_I: begin
        reg_we_i    = 1'b1;
        alu_src_b_i = 1'b1;
        pc_we_i     = 1'b1;
        next_state  = S_FETCH;
      end
      S_ADDR: begin
        alu_src_b_i = 1'b1;
        next_state  = (cls == CLS_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_rd_i = 1'b1;
        if (bus.mem_ready) begin
          next_state = S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        reg_we_i     = 1'b1;
        mem_to_reg_i = 1'b1;
        pc_we_i      = 1'b1;
        next_state   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_wr_i = 1'b1;
        if (bus.mem_ready) begin
          pc_we_i    = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_op_i   = ALU_SUB;
        pc_we_i    = 1'b1;
        pcsel_i    = bus.zero;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pc_we_i    = 1'b1;
        jmp_i      = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP: begin
        next_state = S_TRAP;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

  // reset masks every output in the same cycle, aborting any open request
  assign bus.pc_we      = pc_we_i & ~reset;
  assign bus.pcsel      = pcsel_i & ~reset;
  assign bus.jmp        = jmp_i & ~reset;
  assign bus.ir_we      = ir_we_i & ~reset;
  assign bus.mem_rd     = mem_rd_i & ~reset;
  assign bus.mem_wr     = mem_wr_i & ~reset;
  assign bus.reg_we     = reg_we_i & ~reset;
  assign bus.reg_dst    = reg_dst_i & ~reset;
  assign bus.mem_to_reg = mem_to_reg_i & ~reset;
  assign bus.alu_src_b  = alu_src_b_i & ~reset;
  assign bus.alu_op     = reset ? 3'b000 : alu_op_i;
  assign bus.illegal    = (state == S_TRAP) & ~reset;
  assign bus.retired    = reset ? 32'd0 : retired_cnt;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - directed vector bench for the multicycle controller
module tb_mips_mc_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mips_mc_ctrl_if bus();

  mips_mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       z;
    int         cyc;
    logic [4:0] snap;
  } vec_t;

  vec_t vecs[8];
  int passed = 0;
  int total = 0;
  int exp_ret = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [13:0] outs();
    return {bus.pc_we, bus.pcsel, bus.jmp, bus.ir_we, bus.mem_rd, bus.mem_wr,
            bus.reg_we, bus.reg_dst, bus.mem_to_reg, bus.alu_src_b, bus.alu_op,
            bus.illegal};
  endfunction

  // runs one instruction with zero-wait memory; snapshot is taken in the pc_we cycle
  task automatic run_instr(input string name, input logic [5:0] op, input logic z,
                           output int cyc, output logic [4:0] snap);
    cyc = 0;
    snap = '0;
    for (int i = 1; i <= 20; i++) begin
      #1;
      bus.opcode = op;
      bus.zero = z;
      bus.mem_ready = 1'b1;
      #1;
      if (i == 1) check({name, "_fetch"}, {bus.ir_we, bus.mem_rd}, 2'b11);
      if (bus.pc_we) begin
        cyc = i;
        snap = {bus.pcsel, bus.jmp, bus.reg_we, bus.reg_dst, bus.mem_to_reg};
      end
      @(posedge clk);
      if (cyc != 0) break;
    end
  endtask

  initial begin
    int cyc;
    logic [4:0] snap;

    vecs[0] = '{"rtype",  6'h00, 1'b0, 4, 5'b00110};
    vecs[1] = '{"addi",   6'h08, 1'b0, 4, 5'b00100};
    vecs[2] = '{"lw",     6'h23, 1'b0, 5, 5'b00101};
    vecs[3] = '{"sw",     6'h2B, 1'b0, 4, 5'b00000};
    vecs[4] = '{"beq_t",  6'h04, 1'b1, 3, 5'b10000};
    vecs[5] = '{"beq_nt", 6'h04, 1'b0, 3, 5'b00000};
    vecs[6] = '{"j",      6'h02, 1'b0, 3, 5'b01000};
    vecs[7] = '{"j_z1",   6'h02, 1'b1, 3, 5'b01000};

    bus.opcode = 6'h00;
    bus.funct = 6'h20;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {18'd0, outs()}, 32'd0);
    check("reset_retired", bus.retired, 32'd0);
    bus.mem_ready = 1'b1;
    #1;
    check("reset_mem_rd_masked", {31'd0, bus.mem_rd}, 32'd0);
    reset = 1'b0;

    foreach (vecs[k]) begin
      run_instr(vecs[k].name, vecs[k].op, vecs[k].z, cyc, snap);
      exp_ret++;
      check({vecs[k].name, "_cycles"}, cyc, vecs[k].cyc);
      check({vecs[k].name, "_strobes"}, {27'd0, snap}, {27'd0, vecs[k].snap});
      #1;
      check({vecs[k].name, "_retired"}, bus.retired, exp_ret);
    end

    // lw with two memory wait cycles in MEM_RD
    for (int c = 1; c <= 7; c++) begin
      #1;
      bus.opcode = 6'h23;
      bus.mem_ready = (c == 4 || c == 5) ? 1'b0 : 1'b1;
      #1;
      check($sformatf("lw_wait_pc_we_c%0d", c), {31'd0, bus.pc_we}, {31'd0, c == 7});
      if (c >= 4 && c <= 6) check($sformatf("lw_wait_mem_rd_c%0d", c), {31'd0, bus.mem_rd}, 32'd1);
      if (c == 7) check("lw_wait_wb", {29'd0, bus.reg_we, bus.mem_to_reg, bus.pc_we}, 32'd7);
      @(posedge clk);
    end
    exp_ret++;
    #1;
    check("lw_wait_retired", bus.retired, exp_ret);

    // illegal opcode traps and stays trapped
    for (int c = 1; c <= 8; c++) begin
      #1;
      bus.opcode = 6'h3F;
      bus.mem_ready = 1'b1;
      #1;
      if (c >= 3) check($sformatf("trap_c%0d", c),
                        {28'd0, bus.illegal, bus.pc_we, bus.mem_rd, bus.ir_we}, 32'h8);
      @(posedge clk);
    end
    #1;
    check("trap_retired", bus.retired, exp_ret);
    reset = 1'b1;
    #1;
    check("trap_reset_illegal", {31'd0, bus.illegal}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_ret = 0;
    #1;
    check("trap_cleared", {30'd0, bus.illegal, bus.mem_rd}, 32'd1);
    check("trap_cleared_retired", bus.retired, 32'd0);

    // sw stalled in MEM_WR, then aborted by reset
    for (int c = 1; c <= 4; c++) begin
      #1;
      bus.opcode = 6'h2B;
      bus.mem_ready = (c <= 3) ? 1'b1 : 1'b0;
      #1;
      if (c == 4) check("sw_stall", {30'd0, bus.mem_wr, bus.pc_we}, 32'd2);
      @(posedge clk);
    end
    #1;
    bus.mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("sw_abort_outs", {29'd0, bus.mem_wr, bus.pc_we, bus.mem_rd}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("sw_abort_retired", bus.retired, 32'd0);
    check("sw_abort_fetch", {31'd0, bus.mem_rd}, 32'd1);
    run_instr("post_abort", 6'h00, 1'b0, cyc, snap);
    exp_ret++;
    check("post_abort_cycles", cyc, 4);
    #1;
    check("post_abort_retired", bus.retired, exp_ret);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
